// File: rtl/seg_display_scanner.sv
// Time-multiplexed 4-digit common-anode 7-segment scanner with guard cycles, adjust blink and colon.
// Optional LEADING_ZERO_BLANK_EN blanks a zero hours-tens digit outside adjust mode.
module seg_display_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] hr_tens,
    input  logic [3:0] hr_ones,
    input  logic [2:0] min_tens,
    input  logic [3:0] min_ones,
    input  logic       adjust,
    input  logic [1:0] sel_digit,
    input  logic       sec_tick,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [SW-1:0] slot_cnt;
    logic [1:0]    scan;
    logic [BW-1:0] blink_cnt;
    logic          blink_ph;
    logic          colon;
    logic [3:0]    snap_val;
    logic          snap_adj;
    logic          snap_blank;

    logic          slot_wrap;
    logic          guard_now;
    logic [3:0]    live_val;
    logic [3:0]    live_max;
    logic [3:0]    cur_val;
    logic          cur_adj;
    logic          cur_blank;
    logic          colon_nxt;
    logic [6:0]    seg_dec;

    assign slot_wrap = (slot_cnt == SW'(REFRESH_DIV - 1));
    assign guard_now = (slot_cnt == '0);
    assign colon_nxt = colon ^ sec_tick;

    always_comb begin
        live_val = {2'b00, hr_tens};
        live_max = 4'd2;
        case (scan)
            2'd0: begin live_val = min_ones;         live_max = 4'd9; end
            2'd1: begin live_val = {1'b0, min_tens}; live_max = 4'd5; end
            2'd2: begin live_val = hr_ones;          live_max = 4'd9; end
            default: ;
        endcase
    end

    // During the guard cycle the live inputs are what gets latched, so use them directly.
    assign cur_val   = guard_now ? live_val : snap_val;
    assign cur_adj   = guard_now ? adjust : snap_adj;
    assign cur_blank = guard_now ? (adjust && (sel_digit == scan) && blink_ph) : snap_blank;

    always_comb begin
        seg_dec = 7'b1111111;
        if (cur_val > live_max) begin
            seg_dec = 7'b0111111;
        end else begin
            case (cur_val)
                4'd0: seg_dec = 7'b1000000;
                4'd1: seg_dec = 7'b1111001;
                4'd2: seg_dec = 7'b0100100;
                4'd3: seg_dec = 7'b0110000;
                4'd4: seg_dec = 7'b0011001;
                4'd5: seg_dec = 7'b0010010;
                4'd6: seg_dec = 7'b0000010;
                4'd7: seg_dec = 7'b1111000;
                4'd8: seg_dec = 7'b0000000;
                4'd9: seg_dec = 7'b0010000;
                default: seg_dec = 7'b0111111;
            endcase
        end
`ifdef LEADING_ZERO_BLANK_EN
        if (scan == 2'd3 && cur_val == 4'd0 && !cur_adj)
            seg_dec = 7'b1111111;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt   <= '0;
            scan       <= 2'd0;
            blink_cnt  <= '0;
            blink_ph   <= 1'b0;
            colon      <= 1'b0;
            snap_val   <= 4'd0;
            snap_adj   <= 1'b0;
            snap_blank <= 1'b0;
            an         <= 4'b1111;
            seg        <= 7'b1111111;
            dp         <= 1'b1;
        end else begin
            slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
            if (slot_wrap)
                scan <= scan + 2'd1;

            if (guard_now) begin
                snap_val   <= live_val;
                snap_adj   <= adjust;
                snap_blank <= cur_blank;
            end

            if (!adjust) begin
                blink_cnt <= '0;
                blink_ph  <= 1'b0;
            end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            colon <= colon_nxt;

            // Outputs describe the cycle being entered; a wrap means the next cycle is a guard.
            if (slot_wrap) begin
                an  <= 4'b1111;
                seg <= 7'b1111111;
                dp  <= 1'b1;
            end else begin
                an  <= cur_blank ? 4'b1111 : ~(4'b0001 << scan);
                seg <= seg_dec;
                dp  <= !((scan == 2'd2) && (colon_nxt || cur_adj));
            end
        end
    end
endmodule

// File: tb/tb_seg_display_scanner.sv
// Randomised and directed bench for seg_display_scanner against a slot-level behavioural model.
module tb_seg_display_scanner;
    localparam int R = 4;
    localparam int B = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] hr_tens = 2'd0;
    logic [3:0] hr_ones = 4'd0;
    logic [2:0] min_tens = 3'd0;
    logic [3:0] min_ones = 4'd0;
    logic       adjust = 1'b0;
    logic [1:0] sel_digit = 2'd0;
    logic       sec_tick = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    always #5 clk = ~clk;

    seg_display_scanner #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
        .clk(clk), .rst(rst), .hr_tens(hr_tens), .hr_ones(hr_ones),
        .min_tens(min_tens), .min_ones(min_ones), .adjust(adjust),
        .sel_digit(sel_digit), .sec_tick(sec_tick), .an(an), .seg(seg), .dp(dp)
    );

    int total = 0;
    int bad = 0;

    // Model state: cycle index since reset, what the current slot latched, blink/colon history.
    int t = 0;
    int adj_edges = 0;
    bit colon = 1'b0;
    int m_val = 0;
    bit m_adj = 1'b0;
    bit m_blank = 1'b0;

    function automatic int digit_in(int pos);
        case (pos)
            0: return int'(min_ones);
            1: return int'(min_tens);
            2: return int'(hr_ones);
            default: return int'(hr_tens);
        endcase
    endfunction

    function automatic int max_of(int pos);
        case (pos)
            1: return 5;
            3: return 2;
            default: return 9;
        endcase
    endfunction

    function automatic logic [6:0] pattern(int v, int pos, bit adj);
        logic [6:0] p;
        case (v)
            0: p = 7'b1000000;
            1: p = 7'b1111001;
            2: p = 7'b0100100;
            3: p = 7'b0110000;
            4: p = 7'b0011001;
            5: p = 7'b0010010;
            6: p = 7'b0000010;
            7: p = 7'b1111000;
            8: p = 7'b0000000;
            9: p = 7'b0010000;
            default: p = 7'b0111111;
        endcase
        if (v > max_of(pos)) p = 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
        if (pos == 3 && v == 0 && !adj) p = 7'b1111111;
`endif
        return p;
    endfunction

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s t=%0d got=%b want=%b", tag, t, got, exp);
        end
    endtask

    task automatic tick();
        int slot;
        int scan;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        if (rst) begin
            t = 0; adj_edges = 0; colon = 1'b0;
            m_val = 0; m_adj = 1'b0; m_blank = 1'b0;
        end else begin
            slot = t % R;
            scan = (t / R) % 4;
            if (slot == 0) begin
                m_val   = digit_in(scan);
                m_adj   = adjust;
                m_blank = adjust && (int'(sel_digit) == scan) && (((adj_edges / B) % 2) == 1);
            end
            colon = colon ^ sec_tick;
            adj_edges = adjust ? adj_edges + 1 : 0;
            t++;
        end
        @(posedge clk);
        #1;
        slot = t % R;
        scan = (t / R) % 4;
        if (slot == 0) begin
            e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
        end else begin
            e_an  = m_blank ? 4'b1111 : ~(4'b0001 << scan);
            e_seg = pattern(m_val, scan, m_adj);
            e_dp  = !(scan == 2 && (colon || m_adj));
        end
        chk("an", {3'b000, an}, {3'b000, e_an});
        chk("seg", seg, e_seg);
        chk("dp", {6'b0, dp}, {6'b0, e_dp});
    endtask

    // Advance at least one cycle, stopping when the scan position mod 16 equals target.
    task automatic run_to(input int target);
        for (int i = 0; i < 32; i++) begin
            tick();
            if (t % 16 == target) break;
        end
    endtask

    function automatic logic [3:0] an_of(int pos);
        case (pos)
            0: return 4'b1110;
            1: return 4'b1101;
            2: return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    function automatic logic [6:0] seg_1234(int pos);
        case (pos)
            0: return 7'b0011001;
            1: return 7'b0110000;
            2: return 7'b0100100;
            default: return 7'b1111001;
        endcase
    endfunction

    initial begin
        // Reset with display inputs 1,2,3,4 already applied.
        rst = 1'b1;
        hr_tens = 2'd1; hr_ones = 4'd2; min_tens = 3'd3; min_ones = 4'd4;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            tick();
            if (t % R == 0) chk("guard_an", {3'b000, an}, 7'b0001111);
            else begin
                chk("scan_an", {3'b000, an}, {3'b000, an_of((t / R) % 4)});
                chk("seg_1234", seg, seg_1234((t / R) % 4));
            end
        end

        // Mid-slot change of min_ones must not disturb the current digit-0 slot.
        run_to(1);
        min_ones = 4'd7;
        tick(); chk("hold_seg", seg, 7'b0011001);
        tick(); chk("hold_seg", seg, 7'b0011001);
        run_to(1);
        chk("new_seg", seg, 7'b1111000);

        // Randomised traffic, including out-of-range digits and occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                hr_tens  = 2'($urandom_range(0, 3));
                hr_ones  = 4'($urandom_range(0, 15));
                min_tens = 3'($urandom_range(0, 7));
                min_ones = 4'($urandom_range(0, 15));
            end
            sec_tick = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 49) == 0) adjust = ~adjust;
            if ($urandom_range(0, 24) == 0) sel_digit = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 249) == 0);
            tick();
        end
        rst = 1'b0; sec_tick = 1'b0;

        // Blink of digit 2 in adjust mode.
        hr_tens = 2'd1; hr_ones = 4'd2; min_tens = 3'd3; min_ones = 4'd4;
        adjust = 1'b1; sel_digit = 2'd2;
        for (int i = 0; i < 96; i++) tick();
        adjust = 1'b0;

        // Colon: tick with reset is ignored, then two pulses.
        rst = 1'b1; sec_tick = 1'b1;
        tick(); tick();
        rst = 1'b0; sec_tick = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("dp_off", {6'b0, dp}, 7'd1);
        end
        sec_tick = 1'b1; tick(); sec_tick = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("dp_on", {6'b0, dp}, (t % 16 >= 9 && t % 16 <= 11) ? 7'd0 : 7'd1);
        end
        sec_tick = 1'b1; tick(); sec_tick = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("dp_off2", {6'b0, dp}, 7'd1);
        end

        // Hours-tens zero, adjust visibility, and out-of-range dash.
        hr_tens = 2'd0; adjust = 1'b0;
        run_to(13);
        chk("lz_an", {3'b000, an}, 7'b0000111);
`ifdef LEADING_ZERO_BLANK_EN
        chk("lz_seg", seg, 7'b1111111);
`else
        chk("lz_seg", seg, 7'b1000000);
`endif
        adjust = 1'b1; sel_digit = 2'd0;
        run_to(13);
        chk("lz_adj_seg", seg, 7'b1000000);
        hr_tens = 2'd3;
        run_to(13);
        chk("dash_seg", seg, 7'b0111111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg_display_scanner.md
# seg_display_scanner

- Reads the hour/minute digit counts held by the clock's counter chain and drives a 4-digit, common-anode 7-segment display.
- Time-multiplexed: one digit is active at a time.
- Blinks the digit selected for adjustment and toggles the colon/decimal point once per second.
- Sits between the timekeeping/alarm counters and the board display pins; it is the consumer of the counters' `count` outputs.

## Interface

Parameters:

- `REFRESH_DIV`, default 100000 — clk cycles per digit slot (1 kHz slot rate at 100 MHz); minimum 4.
- `BLINK_DIV`, default 25000000 — clk cycles per blink half-period; minimum 2.

Ports:

- `clk` input 1 — system clock; single clock domain.
- `rst` input 1 — reset, synchronous, active-high.
- `hr_tens` input 2 — hours tens digit, 0–2.
- `hr_ones` input 4 — hours ones digit, 0–9.
- `min_tens` input 3 — minutes tens digit, 0–5.
- `min_ones` input 4 — minutes ones digit, 0–9.
- `adjust` input 1 — adjust mode active; enables blinking of the selected digit.
- `sel_digit` input 2 — digit under adjustment: 0=min_ones, 1=min_tens, 2=hr_ones, 3=hr_tens.
- `sec_tick` input 1 — one-cycle pulse per second; toggles the colon.
- `an` output 4 — digit enables, active-low; bit 0 = min_ones, bit 3 = hr_tens.
- `seg` output 7 — segments {g,f,e,d,c,b,a}, active-low.
- `dp` output 1 — decimal point/colon, active-low; driven only while digit 2 is active.

## Operation

- **Slot counter.** Counts 0..`REFRESH_DIV`-1 and wraps. On wrap, the scan index advances 0→1→2→3→0.
- **Guard cycle.** The first cycle of every slot is a guard cycle: `an`=4'b1111 and `seg`=7'b1111111, which prevents ghosting.
- **Snapshot.** On the guard cycle, the value of the digit about to be shown is sampled into an internal register. The displayed value is held for the rest of the slot even if the counter input changes mid-slot.
- **Decode.** The sampled digit is decoded to standard 7-seg patterns 0–9, e.g. 0 → 7'b1000000 and 1 → 7'b1111001 in {g..a} order.
- **Out-of-range values.** Any value above the digit's legal maximum (hr_tens > 2, min_tens > 5, ones > 9) displays a dash: `seg`=7'b0111111.
- **Blink phase.** A blink counter runs 0..`BLINK_DIV`-1; on wrap the blink phase toggles.
  - When `adjust`=1, `sel_digit` matches the current scan index, and blink phase = 1: `an` for that digit stays high (digit dark) for the whole slot.
  - When `adjust`=0, blinking is suppressed and the blink phase is held at 0.
- **Colon.** Each `sec_tick` toggles the colon state.
  - `dp`=0 only when the scan index is 2, colon state = 1, and it is not a guard cycle.
  - Otherwise `dp`=1.
  - While `adjust`=1 the colon is forced on: `dp`=0 on digit 2.
- **Registered outputs.** `an`, `seg` and `dp` all come straight from flops and update in the same cycle.

## Timing

- **Reset.** While `rst` is high, on the next clk edge:
  - `an`=4'b1111, `seg`=7'b1111111, `dp`=1.
  - Scan index = 0, slot counter = 0, blink counter = 0, blink phase = 0, colon state = 0.
- **After reset.** The first cycle after `rst` falls is the guard cycle of slot 0. digit 0 is lit (`an`=4'b1110) starting from the second cycle.
- **Latency.** One cycle from snapshot to `seg` valid. Input changes appear on the display at the next slot of that digit, within 4×`REFRESH_DIV` cycles.
- **Simultaneous events.**
  - `sec_tick` during a guard cycle toggles the colon normally.
  - `sec_tick` asserted together with `rst` is ignored.
  - A `sel_digit` change takes effect at the next slot boundary.
  - `adjust` falling mid-slot un-blanks at the next slot boundary.
- **Full refresh period.** 4×`REFRESH_DIV` cycles.
- **Blink period.** 2×`BLINK_DIV` cycles.

## Configuration

- `LEADING_ZERO_BLANK_EN`:
  - **Defined:** when `hr_tens`=0 and `adjust`=0, digit 3 shows `seg`=7'b1111111 for its slot; `an[3]` is still driven low.
  - **Undefined:** digit 3 displays "0" normally.
  - **Either way:** while `adjust`=1, digit 3 always shows its value, so the zero is visible during editing.

## Test plan

- Reset with `REFRESH_DIV`=4, then release → `an`=1111 on the guard cycle, then `an`=1110, then a guard cycle, then `an`=1101; the sequence wraps to digit 0 after 16 cycles.
- Inputs 1,2,3,4 (hr_tens..min_ones) → `seg` 7'b1111001 on digit 3, 7'b0100100 on digit 2, 7'b0110000 on digit 1, 7'b0011001 on digit 0.
- `min_ones` changed from 4 to 7 mid-slot of digit 0 → `seg` stays 7'b0011001 until the slot ends; the next digit-0 slot shows 7'b1111000.
- `adjust`=1, `sel_digit`=2, `BLINK_DIV`=8 → `an[2]` stays high for all digit-2 slots while blink phase = 1 and goes low again after the phase toggles; the other digits are unaffected.
- Two `sec_tick` pulses with `adjust`=0 → `dp`=0 on digit-2 slots after the first pulse and `dp`=1 after the second; `dp`=1 on all other digits throughout.
- `hr_tens`=0 with `LEADING_ZERO_BLANK_EN` defined → digit 3 `seg`=7'b1111111. Setting `adjust`=1 → digit 3 shows 7'b1000000. `hr_tens`=3 → dash 7'b0111111.
